// File: rtl/gselect_predictor_p.sv
// gselect conditional-branch predictor: saturating counters indexed by {IP bits, global history},
// multi-lane combinational prediction, speculative history with repair, two-stage commit training.
module gselect_predictor_p #(
   parameter int AW       = 32,
   parameter int IP_LSB   = 3,
   parameter int IP_BITS  = 7,
   parameter int HIST_LEN = 4,
   parameter int CTR_BITS = 2,
   parameter int NLANES   = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   output logic                         ready,
   input  logic                         fetch_valid,
   input  logic [NLANES*AW-1:0]         ip,
   input  logic [NLANES-1:0]            is_branch,
   output logic [NLANES-1:0]            predict_taken,
   output logic [NLANES*HIST_LEN-1:0]   pred_hist,
   input  logic                         c_valid,
   input  logic [AW-1:0]                c_ip,
   input  logic [HIST_LEN-1:0]          c_hist,
   input  logic                         c_takb,
   input  logic                         c_mispredict
);

   localparam int IDX_W = IP_BITS + HIST_LEN;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]          state;
   logic                run;
   logic [IDX_W-1:0]    init_idx;
   logic [HIST_LEN-1:0] spec_hist;
   logic [HIST_LEN-1:0] fetch_hist;
   logic [HIST_LEN-1:0] lane_h;
   logic [IDX_W-1:0]    lane_idx;
   logic                lane_pt;
   logic [CTR_BITS-1:0] ctr_tbl [DEPTH];

   logic                s1_valid;
   logic [IDX_W-1:0]    s1_idx;
   logic                s1_takb;
   logic [CTR_BITS-1:0] s1_ctr;
   logic [CTR_BITS-1:0] s2_ctr;
   logic                s2_we;

   logic [IDX_W-1:0]    c_idx;
   logic                commit;
   logic                repair;
   logic                unused_bits;

   assign run    = (state == S_RUN);
   assign ready  = run;
   assign c_idx  = {c_ip[IP_LSB +: IP_BITS], c_hist};
   assign commit = c_valid & en & run;
   assign repair = commit & c_mispredict;
   assign s2_we  = s1_valid & en;
   // only the indexed IP slice is consumed; the rest of each address is ignored
   assign unused_bits = ^{ip, c_ip};

   always_comb begin
      s2_ctr = s1_ctr;
      if (s1_takb && (s1_ctr != CTR_MAX))
         s2_ctr = s1_ctr + CTR_BITS'(1);
      else if (!s1_takb && (s1_ctr != '0))
         s2_ctr = s1_ctr - CTR_BITS'(1);
   end

   // each younger lane sees the history extended by the predictions of older branch lanes
   always_comb begin
      lane_h        = spec_hist;
      lane_idx      = '0;
      lane_pt       = 1'b0;
      predict_taken = '0;
      pred_hist     = '0;
      for (int unsigned k = 0; k < NLANES; k++) begin
         lane_idx = {ip[k*AW + IP_LSB +: IP_BITS], lane_h};
         lane_pt  = ctr_tbl[lane_idx][CTR_BITS-1] & en & run;
         pred_hist[k*HIST_LEN +: HIST_LEN] = lane_h;
         predict_taken[k] = lane_pt;
         if (is_branch[k])
            lane_h = HIST_LEN'({lane_h, lane_pt});
      end
      fetch_hist = lane_h;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         init_idx  <= '0;
         spec_hist <= '0;
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         s1_takb   <= 1'b0;
         s1_ctr    <= '0;
      end else begin
         if (!run) begin
            init_idx <= init_idx + IDX_W'(1);
            if (&init_idx)
               state <= S_RUN;
         end
         if (repair)
            spec_hist <= HIST_LEN'({c_hist, c_takb});
         else if (fetch_valid && en && run)
            spec_hist <= fetch_hist;
         s1_valid <= commit;
         if (commit) begin
            s1_idx  <= c_idx;
            s1_takb <= c_takb;
            // forward the value being written this edge so back-to-back updates accumulate
            s1_ctr  <= (s2_we && (s1_idx == c_idx)) ? s2_ctr : ctr_tbl[c_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!run)
         ctr_tbl[init_idx] <= CTR_INIT;
      else if (s2_we)
         ctr_tbl[s1_idx] <= s2_ctr;
   end

endmodule

// File: tb/tb_gselect_predictor_p.sv
// Self-checking bench for gselect_predictor_p: directed vector table, hand sequences for
// training/repair/reset corners, and randomized traffic against a behavioural model.
module tb_gselect_predictor_p;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        ready;
   logic        fetch_valid;
   logic [63:0] ip;
   logic [31:0] ip0, ip1;
   logic [1:0]  is_branch;
   logic [1:0]  predict_taken;
   logic [7:0]  pred_hist;
   logic        c_valid;
   logic [31:0] c_ip;
   logic [3:0]  c_hist;
   logic        c_takb;
   logic        c_mispredict;

   assign ip = {ip1, ip0};
   always #5 clk = ~clk;

   gselect_predictor_p #(
      .AW(32), .IP_LSB(3), .IP_BITS(7), .HIST_LEN(4), .CTR_BITS(2), .NLANES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ready(ready), .fetch_valid(fetch_valid),
      .ip(ip), .is_branch(is_branch), .predict_taken(predict_taken), .pred_hist(pred_hist),
      .c_valid(c_valid), .c_ip(c_ip), .c_hist(c_hist), .c_takb(c_takb),
      .c_mispredict(c_mispredict)
   );

   int checks = 0;
   int errors = 0;

   // behavioural model: counters as ints, history as an int, commits applied one edge late
   int ctr_m [DEPTH];
   int spec_m;
   bit ready_m;
   int sweep_m;
   bit pend_v;
   int pend_idx;
   bit pend_t;

   typedef struct {
      logic        en;
      logic        fv;
      logic [1:0]  br;
      logic [31:0] ip0;
      logic [31:0] ip1;
      logic [1:0]  pt;
      logic [7:0]  ph;
   } vec_t;
   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a, input int h);
      return int'((a >> 3) & 32'h7F) * 16 + h;
   endfunction

   task automatic model_pred(output logic [1:0] pt, output logic [7:0] ph, output int nh);
      int h;
      logic [31:0] a;
      h = spec_m;
      for (int k = 0; k < 2; k++) begin
         a = (k == 0) ? ip0 : ip1;
         ph[k*4 +: 4] = 4'(h);
         pt[k] = en && ready_m && (ctr_m[idx_of(a, h)] >= 2);
         if (is_branch[k]) h = ((h * 2) + int'(pt[k])) % 16;
      end
      nh = h;
   endtask

   task automatic tick();
      logic [1:0] pt;
      logic [7:0] ph;
      int nh;
      model_pred(pt, ph, nh);
      if (!rst_n) begin
         sweep_m = 0; ready_m = 0; spec_m = 0; pend_v = 0;
      end else if (!ready_m) begin
         sweep_m++;
         if (sweep_m == DEPTH) begin
            ready_m = 1;
            foreach (ctr_m[i]) ctr_m[i] = 1;
         end
      end else begin
         if (pend_v && en) begin
            if (pend_t) ctr_m[pend_idx] = (ctr_m[pend_idx] < 3) ? ctr_m[pend_idx] + 1 : 3;
            else        ctr_m[pend_idx] = (ctr_m[pend_idx] > 0) ? ctr_m[pend_idx] - 1 : 0;
         end
         pend_v   = c_valid && en;
         pend_idx = idx_of(c_ip, int'(c_hist));
         pend_t   = c_takb;
         if (c_valid && c_mispredict && en) spec_m = (int'(c_hist) * 2 + int'(c_takb)) % 16;
         else if (fetch_valid && en)        spec_m = nh;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      en = 1'b1; fetch_valid = 1'b0; is_branch = 2'b00;
      c_valid = 1'b0; c_ip = '0; c_hist = '0; c_takb = 1'b0; c_mispredict = 1'b0;
   endtask

   task automatic set_commit(input logic [31:0] a, input logic [3:0] h, input logic t, input logic m);
      c_valid = 1'b1; c_ip = a; c_hist = h; c_takb = t; c_mispredict = m;
   endtask

   task automatic sweep_check(input string name);
      for (int k = 1; k <= DEPTH; k++) begin
         fetch_valid = 1'($urandom); is_branch = 2'($urandom);
         ip0 = $urandom; ip1 = $urandom;
         c_valid = 1'($urandom); c_mispredict = 1'($urandom); c_takb = 1'($urandom);
         c_hist = 4'($urandom); c_ip = $urandom;
         #1;
         check({name, "_pt"}, predict_taken, 2'b00);
         tick();
         check({name, "_ready"}, ready, (k == DEPTH));
      end
      set_idle();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] pt_e;
      logic [7:0] ph_e;
      int nh;

      vecs[0] = '{1'b1, 1'b1, 2'b11, 32'h100, 32'h200, 2'b01, 8'h10};
      vecs[1] = '{1'b1, 1'b1, 2'b00, 32'h100, 32'h100, 2'b00, 8'h22};
      vecs[2] = '{1'b1, 1'b1, 2'b01, 32'h200, 32'h100, 2'b00, 8'h42};
      vecs[3] = '{1'b1, 1'b0, 2'b11, 32'h100, 32'h100, 2'b00, 8'h84};
      vecs[4] = '{1'b1, 1'b1, 2'b10, 32'h40,  32'h40,  2'b00, 8'h44};
      vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h40,  32'h40,  2'b00, 8'h08};
      vecs[6] = '{1'b1, 1'b0, 2'b11, 32'h100, 32'h100, 2'b01, 8'h10};
      vecs[7] = '{1'b0, 1'b1, 2'b11, 32'h100, 32'h100, 2'b00, 8'h00};
      vecs[8] = '{1'b1, 1'b0, 2'b11, 32'h100, 32'h100, 2'b01, 8'h10};

      set_idle();
      ip0 = 32'h100; ip1 = 32'h200;
      rst_n = 1'b0;
      sweep_m = 0; ready_m = 0; spec_m = 0; pend_v = 0;
      repeat (3) @(posedge clk);
      #1;
      fetch_valid = 1'b1; is_branch = 2'b11;
      #1;
      check("reset_ready", ready, 1'b0);
      check("reset_pt", predict_taken, 2'b00);
      check("reset_ph", pred_hist, 8'h00);
      tick(); tick();
      @(negedge clk);
      rst_n = 1'b1;
      sweep_check("sweep");

      // fresh table: every counter weakly not-taken, history still zero
      ip0 = 32'h40; ip1 = 32'h80;
      #1;
      check("init_pt", predict_taken, 2'b00);
      check("init_ph", pred_hist, 8'h00);

      // four back-to-back taken commits to one entry, then two not-taken
      set_commit(32'h40, 4'h0, 1'b1, 1'b0);
      tick(); #1; check("collide_old", predict_taken[0], 1'b0);
      tick(); #1; check("ctr_2", predict_taken[0], 1'b1);
      tick(); #1; check("ctr_3", predict_taken[0], 1'b1);
      tick(); c_valid = 1'b0; #1; check("ctr_sat", predict_taken[0], 1'b1);
      tick(); #1; check("ctr_sat_hold", predict_taken[0], 1'b1);
      set_commit(32'h40, 4'h0, 1'b0, 1'b0);
      tick(); tick(); c_valid = 1'b0; #1;
      check("ctr_dec_2", predict_taken[0], 1'b1);
      tick(); #1;
      check("ctr_dec_1", predict_taken[0], 1'b0);

      set_commit(32'h100, 4'h0, 1'b1, 1'b0);
      tick(); tick(); c_valid = 1'b0; tick();

      foreach (vecs[i]) begin
         en = vecs[i].en; fetch_valid = vecs[i].fv; is_branch = vecs[i].br;
         ip0 = vecs[i].ip0; ip1 = vecs[i].ip1;
         #1;
         check($sformatf("vec%0d_pt", i), predict_taken, vecs[i].pt);
         check($sformatf("vec%0d_ph", i), pred_hist, vecs[i].ph);
         tick();
      end
      set_idle();

      // mispredict repair wins over a same-cycle fetch shift
      fetch_valid = 1'b1; is_branch = 2'b11; ip0 = 32'h100; ip1 = 32'h200;
      set_commit(32'h300, 4'b1010, 1'b1, 1'b1);
      #1;
      check("repair_fetch_pt", predict_taken, 2'b01);
      tick();
      set_idle(); ip0 = 32'h200; ip1 = 32'h200;
      #1;
      check("repair_ph", pred_hist, 8'h55);
      check("repair_pt", predict_taken, 2'b00);
      tick();

      // en=0 blocks training, repair, fetch shifting and predictions
      en = 1'b0; fetch_valid = 1'b1; is_branch = 2'b11; ip0 = 32'h80; ip1 = 32'h80;
      set_commit(32'h80, 4'b0101, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("en0_pt", predict_taken, 2'b00);
         check("en0_ph", pred_hist, 8'hA5);
         tick();
      end
      set_idle(); ip0 = 32'h80; ip1 = 32'h80;
      tick();
      #1;
      check("en0_hist_kept", pred_hist, 8'h55);
      check("en0_ctr_kept", predict_taken, 2'b00);

      for (int n = 0; n < 600; n++) begin
         en = ($urandom_range(0, 9) != 0);
         fetch_valid = 1'($urandom); is_branch = 2'($urandom);
         ip0 = ($urandom & 32'hFFFF_FC07) | ($urandom_range(0, 3) << 3);
         ip1 = ($urandom & 32'hFFFF_FC07) | ($urandom_range(0, 3) << 3);
         c_valid = 1'($urandom); c_takb = 1'($urandom);
         c_mispredict = ($urandom_range(0, 7) == 0);
         c_ip = ($urandom & 32'hFFFF_FC07) | ($urandom_range(0, 3) << 3);
         c_hist = ($urandom_range(0, 1) != 0) ? 4'(spec_m) : 4'($urandom);
         #1;
         model_pred(pt_e, ph_e, nh);
         check("rnd_pt", predict_taken, pt_e);
         check("rnd_ph", pred_hist, ph_e);
         check("rnd_ready", ready, ready_m);
         tick();
      end
      set_idle();

      // reset during a sweep restarts it from index 0
      rst_n = 1'b0;
      #1;
      check("rst2_ready", ready, 1'b0);
      check("rst2_ph", pred_hist, 8'h00);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 500; k++) begin
         tick();
         check("partial_sweep_ready", ready, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      check("mid_sweep_rst_ready", ready, 1'b0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      sweep_check("resweep");
      ip0 = 32'h100; ip1 = 32'h100;
      #1;
      check("reinit_pt", predict_taken, 2'b00);
      check("reinit_ph", pred_hist, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
